// File: rtl/bictr_dcnto_arb_pkg.sv
// Shared types and defaults for the counter-sharing arbiter.
//   state_e   : sequencer states (2-bit)
//   WIDTH_DEF : default counter data width
//   NREQ_DEF  : default number of requesters
package bictr_dcnto_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int WIDTH_DEF = 4;
  localparam int NREQ_DEF  = 4;

endpackage

// File: rtl/bictr_dcnto_arb_rr_pick.sv
// Combinational round-robin selector.
//   req_i  : request vector
//   last_i : index of the previous winner
//   win_o  : one-hot winner, lowest index at or after (last_i+1) mod NREQ
//   vld_o  : any request present
module rr_pick
  import bictr_dcnto_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] win_o,
  output logic            vld_o
);

  int idx;

  // Walk the ring starting just past the last winner; the first hit wins.
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_i) + k) % NREQ;
      if (!vld_o && req_i[IW'(idx)]) begin
        win_o[IW'(idx)] = 1'b1;
        vld_o           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bictr_dcnto_arb.sv
// Round-robin sequencer sharing one up/down count-to counter among NREQ
// requesters. A job is granted, the counter loaded with the job's start
// value, run until its terminal flag, then the requester gets a done pulse.
//   clk, rst          : clock, async active-low reset
//   req               : per-requester job request (level, held until done)
//   req_data          : start value per requester, slice i = [i*width +: width]
//   req_count_to      : terminal value per requester
//   req_up_dn         : direction per requester, 1 = up
//   gnt               : registered one-hot grant
//   done              : one-cycle completion pulse
//   busy              : sequencer not idle
//   ctr_load/cen/up_dn/data/count_to : drive the shared counter (load active-low)
//   ctr_count, ctr_tercnt             : from the shared counter
module bictr_dcnto_arb
  import bictr_dcnto_arb_pkg::*;
#(
  parameter int width = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*width-1:0] req_data,
  input  logic [NREQ*width-1:0] req_count_to,
  input  logic [NREQ-1:0]       req_up_dn,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  ctr_load,
  output logic                  ctr_cen,
  output logic                  ctr_up_dn,
  output logic [width-1:0]      ctr_data,
  output logic [width-1:0]      ctr_count_to,
  input  logic [width-1:0]      ctr_count,
  input  logic                  ctr_tercnt
);

  localparam int IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     id_q, id_d, last_q, last_d;
  logic [width-1:0]  data_q, data_d, cto_q, cto_d;
  logic              up_q, up_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic [NREQ-1:0]   win_oh;
  logic              win_vld;
  logic [IW-1:0]     win_id;
  logic [width-1:0]  win_data, win_cto;
  logic              win_up;
  logic              req_held;

  // Count value is debug-only; nothing here depends on it.
  logic unused_ctr_count;
  assign unused_ctr_count = ^ctr_count;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (win_oh),
    .vld_o  (win_vld)
  );

  // Encode the winner and select its job fields.
  always_comb begin
    win_id   = '0;
    win_data = '0;
    win_cto  = '0;
    win_up   = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_id   = IW'(i);
        win_data = req_data[i*width +: width];
        win_cto  = req_count_to[i*width +: width];
        win_up   = req_up_dn[i];
      end
    end
  end

  assign req_held = req[id_q];

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    data_d   = data_q;
    cto_d    = cto_q;
    up_d     = up_q;
    gnt_d    = gnt_q;
    ctr_load = 1'b1;
    ctr_cen  = 1'b0;
    done     = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          data_d  = win_data;
          cto_d   = win_cto;
          up_d    = win_up;
          gnt_d   = win_oh;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ctr_load = 1'b0;
        if (!req_held) begin
          gnt_d   = '0;
          last_d  = id_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over terminal count; the counter freezes either way.
        if (!req_held) begin
          gnt_d   = '0;
          last_d  = id_q;
          state_d = S_IDLE;
        end else begin
          ctr_cen = ~ctr_tercnt;
          if (ctr_tercnt) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = gnt_q;
        gnt_d   = '0;
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      last_q  <= IW'(NREQ - 1);  // so requester 0 is first in line
      data_q  <= '0;
      cto_q   <= '0;
      up_q    <= 1'b1;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cto_q   <= cto_d;
      up_q    <= up_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign busy         = (state_q != S_IDLE);
  assign ctr_up_dn    = up_q;
  assign ctr_data     = data_q;
  assign ctr_count_to = cto_q;

endmodule

// File: tb/tb_bictr_dcnto_arb.sv
// Directed bench for bictr_dcnto_arb with a behavioural up/down count-to
// counter standing in for the shared counter instance.
module tb_bictr_dcnto_arb;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N*W-1:0] req_count_to;
  logic [N-1:0]   req_up_dn;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic           ctr_load;
  logic           ctr_cen;
  logic           ctr_up_dn;
  logic [W-1:0]   ctr_data;
  logic [W-1:0]   ctr_count_to;
  logic [W-1:0]   ctr_count;
  logic           ctr_tercnt;

  int checks   = 0;
  int failures = 0;

  bictr_dcnto_arb #(.width(W), .NREQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_count_to (req_count_to),
    .req_up_dn    (req_up_dn),
    .gnt          (gnt),
    .done         (done),
    .busy         (busy),
    .ctr_load     (ctr_load),
    .ctr_cen      (ctr_cen),
    .ctr_up_dn    (ctr_up_dn),
    .ctr_data     (ctr_data),
    .ctr_count_to (ctr_count_to),
    .ctr_count    (ctr_count),
    .ctr_tercnt   (ctr_tercnt)
  );

  // Shared counter: synchronous active-low load, enable, up/down, count-to flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           ctr_count <= '0;
    else if (!ctr_load) ctr_count <= ctr_data;
    else if (ctr_cen)   ctr_count <= ctr_up_dn ? ctr_count + 1'b1 : ctr_count - 1'b1;
  end
  assign ctr_tercnt = (ctr_count == ctr_count_to);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job on requester idx; d is the hand-computed step count.
  task automatic run_job(input int idx, input logic [W-1:0] d0, input logic [W-1:0] ct,
                         input logic up, input int d, input string tag);
    int n, runc, cenc;
    bit seen;
    logic [N-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[idx] = 1'b1;
    req_data[idx*W +: W]     = d0;
    req_count_to[idx*W +: W] = ct;
    req_up_dn[idx]           = up;
    req[idx]                 = 1'b1;
    n = 0; runc = 0; cenc = 0; seen = 0;
    while (!seen && n < 60) begin
      tick();
      n++;
      // Job fields are latched at grant; scrambling the inputs must not matter.
      if (n == 1) begin
        req_data[idx*W +: W]     = ~d0;
        req_count_to[idx*W +: W] = ~ct;
        req_up_dn[idx]           = ~up;
      end
      if (busy) chk({tag, "_gnt"}, 32'(gnt), 32'(exp_oh));
      if (busy && ctr_load && done == '0) runc++;
      if (ctr_cen) cenc++;
      if (done != '0) seen = 1;
    end
    chk({tag, "_done"},    32'(done), 32'(exp_oh));
    chk({tag, "_latency"}, n, d + 3);
    chk({tag, "_run"},     runc, d + 1);
    chk({tag, "_steps"},   cenc, d);
    chk({tag, "_count"},   32'(ctr_count), 32'(ct));
    req[idx] = 1'b0;
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_gnt"},  32'(gnt), 0);
    chk({tag, "_idle_done"}, 32'(done), 0);
    chk({tag, "_data_held"}, 32'(ctr_data), 32'(d0));
  endtask

  initial begin
    int n, gi, ndone, last_done_n;
    int order [4];
    logic [N-1:0] prev_gnt;
    bit saw3;

    rst = 1'b0; req = '0; req_data = '0; req_count_to = '0; req_up_dn = '0;

    // Reset held with random inputs.
    repeat (3) begin
      req          = 4'($urandom);
      req_data     = 16'($urandom);
      req_count_to = 16'($urandom);
      req_up_dn    = 4'($urandom);
      tick();
    end
    chk("rst_gnt",      32'(gnt), 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_load",     32'(ctr_load), 1);
    chk("rst_cen",      32'(ctr_cen), 0);
    chk("rst_updn",     32'(ctr_up_dn), 1);
    chk("rst_data",     32'(ctr_data), 0);
    chk("rst_countto",  32'(ctr_count_to), 0);

    req = '0; req_data = '0; req_count_to = '0; req_up_dn = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_gnt",  32'(gnt), 0);
    chk("idle_load", 32'(ctr_load), 1);

    run_job(0, 4'd10, 4'd4, 1'b1, 10, "up_wrap");
    run_job(1, 4'd10, 4'd4, 1'b0, 6,  "down");
    run_job(2, 4'd7,  4'd7, 1'b1, 0,  "equal");

    // Round-robin between requesters 0 and 2, each d=2; last winner is 2.
    req_data[0 +: W] = 4'd1; req_count_to[0 +: W] = 4'd3; req_up_dn[0] = 1'b1;
    req_data[8 +: W] = 4'd9; req_count_to[8 +: W] = 4'd7; req_up_dn[2] = 1'b0;
    req = 4'b0101;
    n = 0; gi = 0; ndone = 0; last_done_n = -1; prev_gnt = '0;
    while (ndone < 4 && n < 80) begin
      tick();
      n++;
      chk("rr_onehot", 32'($countones(gnt) <= 1), 1);
      if (gnt != '0 && prev_gnt == '0) begin
        if (gi < 4) begin
          for (int i = 0; i < N; i++) if (gnt[i]) order[gi] = i;
          gi++;
        end
        if (last_done_n >= 0) chk("rr_gap", n - last_done_n, 2);
      end
      if (done != '0) begin
        ndone++;
        last_done_n = n;
        if (ndone == 4) req = '0;
      end
      prev_gnt = gnt;
    end
    chk("rr_jobs", ndone, 4);
    chk("rr_grants", gi, 4);
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 2);
    chk("rr_order2", order[2], 0);
    chk("rr_order3", order[3], 2);
    tick();
    chk("rr_end_busy", 32'(busy), 0);

    // Abort: requester 3 counts 0->15, drops after three steps.
    req_data[12 +: W] = 4'd0; req_count_to[12 +: W] = 4'd15; req_up_dn[3] = 1'b1;
    req_data[0 +: W]  = 4'd5; req_count_to[0 +: W]  = 4'd5;  req_up_dn[0] = 1'b1;
    req = 4'b1000;
    repeat (5) tick();
    chk("abort_gnt_run", 32'(gnt), 32'(4'b1000));
    chk("abort_cnt_pre", 32'(ctr_count), 3);
    req = 4'b0001;
    tick();
    chk("abort_cen",  32'(ctr_cen), 0);
    chk("abort_gnt",  32'(gnt), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cnt",  32'(ctr_count), 3);
    tick();
    chk("abort_next_gnt", 32'(gnt), 32'(4'b0001));
    saw3 = 0; n = 0;
    while (done == '0 && n < 40) begin
      tick();
      n++;
      if (done[3]) saw3 = 1;
    end
    chk("abort_no_done3", 32'(saw3), 0);
    chk("abort_next_done", 32'(done), 32'(4'b0001));
    req = '0;
    tick();

    // Reset mid-RUN on requester 1.
    req_data[4 +: W] = 4'd0; req_count_to[4 +: W] = 4'd8; req_up_dn[1] = 1'b0;
    req = 4'b0010;
    repeat (4) tick();
    chk("midrst_pre_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("midrst_gnt",     32'(gnt), 0);
    chk("midrst_done",    32'(done), 0);
    chk("midrst_busy",    32'(busy), 0);
    chk("midrst_load",    32'(ctr_load), 1);
    chk("midrst_cen",     32'(ctr_cen), 0);
    chk("midrst_updn",    32'(ctr_up_dn), 1);
    chk("midrst_data",    32'(ctr_data), 0);
    chk("midrst_countto", 32'(ctr_count_to), 0);
    tick();
    req = 4'b1001;
    rst = 1'b1;
    tick();
    chk("postrst_first_gnt", 32'(gnt), 32'(4'b0001));
    req = '0;
    tick();
    chk("postrst_abort_busy", 32'(busy), 0);
    chk("postrst_abort_done", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bictr_dcnto_arb.md
Name: bictr_dcnto_arb

Overview:
Round-robin arbiter and sequencer that shares one up/down binary counter with dynamic count-to flag (DW03_bictr_dcnto) between NREQ requesters. Each requester asks for a count job: start value, count-to value and direction. The block grants one requester at a time, loads the counter, runs it until the terminal flag, then pulses that requester's done. It sits between client timers and the single shared counter instance.

Parameters:
width, 4, counter data width (matches counter instance)
NREQ, 4, number of requesters (2..8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  NREQ  per-requester job request; level, held until done
req_data  in  NREQ*width  start value per requester, slice i = bits [i*width +: width]
req_count_to  in  NREQ*width  terminal value per requester
req_up_dn  in  NREQ  direction per requester, 1 = up
gnt  out  NREQ  one-hot grant; registered
done  out  NREQ  one-cycle completion pulse to the granted requester
busy  out  1  high whenever state != IDLE
ctr_load  out  1  to counter load, active-low
ctr_cen  out  1  to counter cen
ctr_up_dn  out  1  to counter up_dn
ctr_data  out  width  to counter data
ctr_count_to  out  width  to counter count_to
ctr_count  in  width  from counter count (monitoring; visible as debug)
ctr_tercnt  in  1  from counter tercnt (count == count_to)

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, done=0, busy=0, ctr_load=1, ctr_cen=0, ctr_up_dn=1, ctr_data=0, ctr_count_to=0, rr pointer favours requester 0 first. Reset mid-job abandons it with no done.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: if any req, pick winner by round-robin: lowest index at or after (last_winner+1) mod NREQ. Latch id, data, count_to and up_dn into registers → LOAD. The latched values drive ctr_data, ctr_count_to and ctr_up_dn and stay stable until the next grant, even if the requester's inputs change.
- LOAD (1 cycle): gnt[id]=1, ctr_load=0, ctr_cen=0 → RUN. The counter holds data after this edge.
- RUN: ctr_load=1, ctr_cen = ~ctr_tercnt (combinational), so the counter stops exactly on count_to. When ctr_tercnt=1 → DONE.
- RUN length is d+1 cycles. For up, d = (count_to - data) mod 2^width. For down, d = (data - count_to) mod 2^width. Wrap-around is inherent.
- data == count_to gives a RUN of 1 cycle and zero count steps.
- DONE (1 cycle): done[id]=1, gnt[id]=1, ctr_cen=0, last_winner=id → IDLE. gnt drops on the next cycle.
- Minimum job latency: req sampled at edge 0 → done high in cycle d+3.
- Abort: if req[id] drops in LOAD or RUN, then ctr_cen=0 and gnt drops next cycle. No done pulse. last_winner=id, → IDLE.
- Back-to-back: a req still high in DONE is not re-granted until a later IDLE cycle. One IDLE cycle always separates jobs.
- tercnt is ignored outside RUN. Counter count values are never modified except via load.

Decomposition:
- Package bictr_dcnto_arb_pkg holds the state enum (IDLE/LOAD/RUN/DONE, 2-bit) and default WIDTH/NREQ constants.
- One sub-module, rr_pick: combinational round-robin selector with inputs req and last_winner, outputs a one-hot winner and a valid flag.
- The bench instantiates bictr_dcnto_arb together with DW03_bictr_dcnto.

Test Plan:
- Reset: hold rst=0 with random inputs → gnt=0, done=0, busy=0, ctr_load=1, ctr_cen=0, ctr_up_dn=1. Release → IDLE, no activity with req=0.
- Up with wrap: req[0], data=10, count_to=4, up → counter goes 10..15,0..4. RUN lasts 11 cycles, done[0] in cycle 13 after request, count=4 held.
- Down: req[1], data=10, count_to=4, down → RUN 7 cycles (10..4), done[1] in cycle 9.
- Equal values: req[2], data=7, count_to=7 → RUN 1 cycle, done[2] in cycle 3, counter never enabled.
- Round-robin: req[0] and req[2] held high, each with d=2 → grant order 0,2,0,2. Exactly one gnt bit high at any time, one IDLE cycle between jobs.
- Abort and reset: drop req[3] mid-RUN → no done[3], ctr_cen=0 next cycle, next grant goes to requester 0. Separately, assert rst mid-RUN → all outputs return to reset values immediately.
